// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
//   Synthesizable test-pattern camera source. It drives frame_valid, line_valid
//   and pixel_data in the sensor-bus format that the histogram/capture path
//   expects. Frames can be started by a trigger or run back to back.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   en                  level enable; gates the start of new frames
//   trigger             frame-start request, sampled only in IDLE
//   free_run            1: the next frame follows FV_BLANK automatically
//   mode                pattern select, latched at frame start
//   num_frames          frames per sequence (0 = unlimited), latched at sequence start
//   seed                constant value / LFSR seed, latched at frame start
//   frame_valid         frame sync
//   line_valid          line sync
//   pixel_data          pixel value (0 outside line_valid)
//   frame_idx           index of the current/last frame of the sequence
//   busy                high while not IDLE
//   done                one-cycle pulse at sequence end
module camera_pattern_gen #(
  parameter int PIX_W    = 10,
  parameter int WIDTH    = 1920,
  parameter int HEIGHT   = 1280,
  parameter int LV_BLANK = 10,
  parameter int FV_SETUP = 2,
  parameter int FV_BLANK = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             trigger,
  input  logic             free_run,
  input  logic [2:0]       mode,
  input  logic [7:0]       num_frames,
  input  logic [15:0]      seed,
  output logic             frame_valid,
  output logic             line_valid,
  output logic [PIX_W-1:0] pixel_data,
  output logic [7:0]       frame_idx,
  output logic             busy,
  output logic             done
);

  localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CMAX = (FV_SETUP > LV_BLANK) ?
                        ((FV_SETUP > FV_BLANK) ? FV_SETUP : FV_BLANK) :
                        ((LV_BLANK > FV_BLANK) ? LV_BLANK : FV_BLANK);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [XW-1:0] X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(FV_SETUP - 1);
  localparam logic [CW-1:0] LBLANK_LAST = CW'(LV_BLANK - 1);
  localparam logic [CW-1:0] FBLANK_LAST = CW'(FV_BLANK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LINE, S_LBLANK, S_FBLANK
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]  mode_q;
  logic [15:0] seed_q;
  logic [15:0] lfsr;
  logic [7:0]  nf_q;
  logic [7:0]  frames_done;
  // A frame ended in trigger mode without closing the sequence: the next
  // trigger continues it instead of starting a new one.
  logic        seq_open;

  // 16-bit Galois LFSR, right shift, taps 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Pixel value for coordinate (px, py); sums are formed 32 bits wide and
  // truncated to PIX_W at the end.
  function automatic logic [PIX_W-1:0] pattern(
    input logic [2:0]    m,
    input logic [XW-1:0] px,
    input logic [YW-1:0] py,
    input logic [7:0]    fi,
    input logic [15:0]   sd,
    input logic [15:0]   lf
  );
    logic [31:0] xw, yw, v;
    xw = 32'(px);
    yw = 32'(py);
    case (m)
      3'd1:    v = yw;
      3'd2:    v = (xw[3] ^ yw[3]) ? '1 : '0;
      3'd3:    v = 32'(sd);
      3'd4:    v = 32'(lf);
      3'd5:    v = xw + 32'(fi);
      default: v = xw + yw;
    endcase
    return v[PIX_W-1:0];
  endfunction

  // Outputs are registered alongside the state: every transition assigns the
  // output values belonging to the cycle it enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      lfsr        <= '0;
      nf_q        <= '0;
      frames_done <= '0;
      seq_open    <= 1'b0;
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      pixel_data  <= '0;
      frame_idx   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && trigger) begin
            state       <= S_SETUP;
            cnt         <= '0;
            x           <= '0;
            y           <= '0;
            mode_q      <= mode;
            seed_q      <= seed;
            lfsr        <= (seed == 16'd0) ? 16'hACE1 : seed;
            frame_valid <= 1'b1;
            busy        <= 1'b1;
            if (seq_open) begin
              frame_idx <= frame_idx + 8'd1;
            end else begin
              nf_q        <= num_frames;
              frames_done <= '0;
              frame_idx   <= '0;
            end
          end
        end

        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state      <= S_LINE;
            cnt        <= '0;
            x          <= '0;
            line_valid <= 1'b1;
            pixel_data <= pattern(mode_q, '0, y, frame_idx, seed_q, lfsr);
            lfsr       <= lfsr_step(lfsr);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LINE: begin
          if (x == X_LAST) begin
            line_valid <= 1'b0;
            pixel_data <= '0;
            cnt        <= '0;
            if (y != Y_LAST) begin
              state <= S_LBLANK;
              y     <= y + 1'b1;
            end else begin
              // last line of the frame: no line blank, straight to frame blank
              state       <= S_FBLANK;
              frame_valid <= 1'b0;
              frames_done <= frames_done + 8'd1;
            end
          end else begin
            x          <= x + 1'b1;
            pixel_data <= pattern(mode_q, x + 1'b1, y, frame_idx, seed_q, lfsr);
            lfsr       <= lfsr_step(lfsr);
          end
        end

        S_LBLANK: begin
          if (cnt == LBLANK_LAST) begin
            state      <= S_LINE;
            cnt        <= '0;
            x          <= '0;
            line_valid <= 1'b1;
            pixel_data <= pattern(mode_q, '0, y, frame_idx, seed_q, lfsr);
            lfsr       <= lfsr_step(lfsr);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_FBLANK: begin
          if (cnt == FBLANK_LAST) begin
            cnt <= '0;
            if (((nf_q != 8'd0) && (frames_done == nf_q)) || !en) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              seq_open <= 1'b0;
            end else if (free_run) begin
              state       <= S_SETUP;
              x           <= '0;
              y           <= '0;
              mode_q      <= mode;
              seed_q      <= seed;
              lfsr        <= (seed == 16'd0) ? 16'hACE1 : seed;
              frame_valid <= 1'b1;
              frame_idx   <= frame_idx + 8'd1;
            end else begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              seq_open <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_pattern_gen.sv
// tb_camera_pattern_gen
//   Directed/randomized bench for camera_pattern_gen. Two instances: a tiny
//   4x3 geometry (a) and a 32x16 geometry (b). Expected per-cycle output
//   streams are built from the frame-geometry and pattern rules.
module tb_camera_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, trig_a, trig_b, free_run;
  logic [2:0]  mode;
  logic [7:0]  num_frames;
  logic [15:0] seed;

  logic       fv_a, lv_a, busy_a, done_a, fv_b, lv_b, busy_b, done_b;
  logic [9:0] pd_a, pd_b;
  logic [7:0] fi_a, fi_b;

  camera_pattern_gen #(.PIX_W(10), .WIDTH(4), .HEIGHT(3), .LV_BLANK(2),
                       .FV_SETUP(1), .FV_BLANK(3)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .trigger(trig_a), .free_run(free_run),
    .mode(mode), .num_frames(num_frames), .seed(seed),
    .frame_valid(fv_a), .line_valid(lv_a), .pixel_data(pd_a),
    .frame_idx(fi_a), .busy(busy_a), .done(done_a));

  camera_pattern_gen #(.PIX_W(10), .WIDTH(32), .HEIGHT(16), .LV_BLANK(2),
                       .FV_SETUP(2), .FV_BLANK(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .trigger(trig_b), .free_run(free_run),
    .mode(mode), .num_frames(num_frames), .seed(seed),
    .frame_valid(fv_b), .line_valid(lv_b), .pixel_data(pd_b),
    .frame_idx(fi_b), .busy(busy_b), .done(done_b));

  // {frame_valid, line_valid, pixel_data, busy, done, frame_idx}
  logic [21:0] obs_a, obs_b;
  assign obs_a = {fv_a, lv_a, pd_a, busy_a, done_a, fi_a};
  assign obs_b = {fv_b, lv_b, pd_b, busy_b, done_b, fi_b};

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [9:0] mpix(input int m, input int x, input int y, input int f,
                                      input logic [15:0] sd, input logic [15:0] lf);
    int v;
    case (m)
      1:       v = y;
      2:       v = (((x / 8) % 2) != ((y / 8) % 2)) ? 1023 : 0;
      3:       v = int'(sd);
      4:       v = int'(lf);
      5:       v = x + f;
      default: v = x + y;
    endcase
    return v[9:0];
  endfunction

  // Pulse the selected trigger; returns sampling the first frame cycle (SETUP).
  task automatic start(input int s);
    if (s == 1) trig_b = 1'b1; else trig_a = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
    trig_b = 1'b0;
  endtask

  // Checks one whole frame (SETUP..FBLANK) cycle by cycle; returns sampling
  // the cycle after FBLANK. poke 1: trigger pulse at poke_at; 2: drop en.
  task automatic check_frame(input int s, input logic [2:0] m, input logic [15:0] sd,
                             input logic [7:0] f, input int poke, input int poke_at);
    int w, h, lb, fs, fb;
    logic [21:0] q[$];
    logic [15:0] lf;
    if (s == 1) begin w = 32; h = 16; lb = 2; fs = 2; fb = 4; end
    else        begin w = 4;  h = 3;  lb = 2; fs = 1; fb = 3; end
    lf = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int i = 0; i < fs; i++) q.push_back({1'b1, 1'b0, 10'd0, 1'b1, 1'b0, f});
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        q.push_back({1'b1, 1'b1, mpix(int'(m), xx, yy, int'(f), sd, lf), 1'b1, 1'b0, f});
        lf = lstep(lf);
      end
      if (yy < h - 1)
        for (int i = 0; i < lb; i++) q.push_back({1'b1, 1'b0, 10'd0, 1'b1, 1'b0, f});
    end
    for (int i = 0; i < fb; i++) q.push_back({1'b0, 1'b0, 10'd0, 1'b1, 1'b0, f});
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("frame s%0d m%0d f%0d c%0d", s, m, f, i), (s == 1) ? obs_b : obs_a, q[i]);
      if (poke == 1 && i == poke_at) begin
        if (s == 1) trig_b = 1'b1; else trig_a = 1'b1;
      end
      if (poke == 1 && i == poke_at + 1) begin trig_a = 1'b0; trig_b = 1'b0; end
      if (poke == 2 && i == poke_at) en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Single-frame sequence (num_frames=1, trigger mode) including the done pulse.
  task automatic one_frame(input int s, input logic [2:0] m, input logic [15:0] sd);
    mode = m;
    seed = sd;
    start(s);
    check_frame(s, m, sd, 8'd0, 0, 0);
    chk("exit_done", (s == 1) ? obs_b : obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'd0});
    @(posedge clk); #1;
    chk("after_done", (s == 1) ? obs_b : obs_a, 22'd0);
  endtask

  initial begin
    logic [15:0] sd;
    rst_n = 1'b0; en = 1'b0; trig_a = 1'b0; trig_b = 1'b0; free_run = 1'b0;
    mode = '0; num_frames = '0; seed = '0;
    #12;
    chk("reset_a", obs_a, 22'd0);
    chk("reset_b", obs_b, 22'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // basic 4x3 ramp frame, then LFSR seeds 1 and 0
    en = 1'b1; num_frames = 8'd1;
    one_frame(0, 3'd0, 16'h0000);
    one_frame(0, 3'd4, 16'h0001);
    one_frame(0, 3'd4, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      sd = 16'($urandom);
      one_frame(0, 3'($urandom_range(0, 7)), sd);
    end

    // 32x16: checkerboard, then a random mode
    one_frame(1, 3'd2, 16'($urandom));
    one_frame(1, 3'($urandom_range(0, 7)), 16'($urandom));

    // free-run sequence of 3 moving-ramp frames
    free_run = 1'b1; num_frames = 8'd3; mode = 3'd5; seed = 16'($urandom);
    start(0);
    for (int k = 0; k < 3; k++) check_frame(0, 3'd5, seed, 8'(k), 0, 0);
    chk("fr_done", obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'd2});
    @(posedge clk); #1;
    chk("fr_after", obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'd2});
    free_run = 1'b0;

    // trigger mode, unlimited: no done, next trigger continues sequence
    num_frames = 8'd0; mode = 3'd1; seed = 16'($urandom);
    start(0);
    check_frame(0, 3'd1, seed, 8'd0, 1, 6);
    chk("tm_exit", obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'd0});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("tm_idle", obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'd0});
    end
    start(0);
    check_frame(0, 3'd1, seed, 8'd1, 0, 0);
    chk("tm_exit2", obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 8'd1});

    // asynchronous reset in the middle of a line
    mode = 3'd0; num_frames = 8'd1;
    start(0);
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 chk("async_rst_a", obs_a, 22'd0);
    chk("async_rst_b", obs_b, 22'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", obs_a, 22'd0);
    end
    en = 1'b0; trig_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("en_low_trig", obs_a, 22'd0);
    end
    trig_a = 1'b0; en = 1'b1;
    one_frame(0, 3'd0, 16'($urandom));

    // en dropped mid-frame in free-run unlimited mode: frame completes, done
    free_run = 1'b1; num_frames = 8'd0; mode = 3'd3; seed = 16'($urandom);
    start(0);
    check_frame(0, 3'd3, seed, 8'd0, 2, 10);
    chk("en_drop_done", obs_a, {1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 8'd0});
    @(posedge clk); #1;
    chk("en_drop_after", obs_a, 22'd0);
    free_run = 1'b0; en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
